// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - fetch/stage-register bundle of the pipeline hazard controller
//
// Purpose: groups the fetch inputs, stage instruction/PC registers and the
//          stall / multiply-divide status of pipe_hazard_ctrl.
// Signals:
//   IR_F, PC_F              fetched instruction and its PC
//   IR_D..IR_W, PC_D..PC_W  stage instruction and PC registers
//   stall, en_PC            hold F/D + bubble E; fetch PC write enable
//   md_busy, md_cnt         multiply/divide unit busy flag and remaining cycles
// Modports: master = fetch side / environment, slave = hazard controller.
interface pipe_hazard_ctrl_if;
  logic [31:0] IR_F;
  logic [31:0] PC_F;
  logic [31:0] IR_D;
  logic [31:0] IR_E;
  logic [31:0] IR_M;
  logic [31:0] IR_W;
  logic [31:0] PC_D;
  logic [31:0] PC_E;
  logic [31:0] PC_M;
  logic [31:0] PC_W;
  logic        stall;
  logic        en_PC;
  logic        md_busy;
  logic [3:0]  md_cnt;

  modport master (
    output IR_F, PC_F,
    input  IR_D, IR_E, IR_M, IR_W, PC_D, PC_E, PC_M, PC_W,
    input  stall, en_PC, md_busy, md_cnt
  );

  modport slave (
    input  IR_F, PC_F,
    output IR_D, IR_E, IR_M, IR_W, PC_D, PC_E, PC_M, PC_W,
    output stall, en_PC, md_busy, md_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - D/E/M/W pipeline registers with stall and bubble control
//
// Purpose: holds IR/PC for stages D, E, M, W of a 5-stage MIPS pipeline and
//          stalls on hazards forwarding cannot cover: load-use, branch/jr
//          operand, and multiply/divide unit busy.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    pipe_hazard_ctrl_if.slave: IR_F/PC_F in; IR_x/PC_x, stall,
//          en_PC, md_busy, md_cnt out
module pipe_hazard_ctrl #(
  parameter int          MULT_CYC = 5,
  parameter int          DIV_CYC  = 10,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  // ---------------- instruction classification ----------------
  function automatic logic is_special(input logic [31:0] ir);
    return ir[31:26] == OP_SPECIAL;
  endfunction

  // Register-register ALU ops, including variable shifts (use rs and rt).
  function automatic logic is_cal_r(input logic [31:0] ir);
    if (!is_special(ir)) return 1'b0;
    case (ir[5:0])
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // sll/srl/sra take their shift amount from the instruction, so only rt is read.
  function automatic logic is_shift_imm(input logic [31:0] ir);
    return is_special(ir) && (ir[5:0] == 6'h00 || ir[5:0] == 6'h02 || ir[5:0] == 6'h03);
  endfunction

  function automatic logic is_mf(input logic [31:0] ir);
    return is_special(ir) && (ir[5:0] == F_MFHI || ir[5:0] == F_MFLO);
  endfunction

  function automatic logic is_mt(input logic [31:0] ir);
    return is_special(ir) && (ir[5:0] == F_MTHI || ir[5:0] == F_MTLO);
  endfunction

  function automatic logic is_mult(input logic [31:0] ir);
    return is_special(ir) && (ir[5:0] == F_MULT || ir[5:0] == F_MULTU);
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return is_special(ir) && (ir[5:0] == F_DIV || ir[5:0] == F_DIVU);
  endfunction

  function automatic logic is_jr(input logic [31:0] ir);
    return is_special(ir) && ir[5:0] == F_JR;
  endfunction

  function automatic logic is_jalr(input logic [31:0] ir);
    return is_special(ir) && ir[5:0] == F_JALR;
  endfunction

  function automatic logic is_cal_i(input logic [31:0] ir);
    return ir[31:26] >= 6'h08 && ir[31:26] <= 6'h0f;
  endfunction

  function automatic logic is_load(input logic [31:0] ir);
    case (ir[31:26])
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [31:0] ir);
    case (ir[31:26])
      6'h28, 6'h29, 6'h2b: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_md(input logic [31:0] ir);
    return is_mult(ir) || is_div(ir) || is_mf(ir) || is_mt(ir);
  endfunction

  // ---------------- destination / Tnew / Tuse ----------------
  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    if (is_cal_r(ir) || is_shift_imm(ir) || is_mf(ir) || is_jalr(ir)) return ir[15:11];
    if (is_cal_i(ir) || is_load(ir)) return ir[20:16];
    if (ir[31:26] == OP_JAL) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic [1:0] tnew_e_of(input logic [31:0] ir);
    if (is_load(ir)) return 2'd2;
    if (is_cal_r(ir) || is_shift_imm(ir) || is_mf(ir) || is_jalr(ir) ||
        is_cal_i(ir) || ir[31:26] == OP_JAL) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] tnew_m_of(input logic [31:0] ir);
    return is_load(ir) ? 2'd1 : 2'd0;
  endfunction

  // {used, tuse[1:0]}
  function automatic logic [2:0] rs_use_of(input logic [31:0] ir);
    if (ir[31:26] == OP_BEQ || is_jr(ir) || is_jalr(ir)) return 3'b1_00;
    if (is_cal_r(ir) || is_cal_i(ir) || is_load(ir) || is_store(ir) ||
        is_mult(ir) || is_div(ir) || is_mt(ir)) return 3'b1_01;
    return 3'b0_00;
  endfunction

  function automatic logic [2:0] rt_use_of(input logic [31:0] ir);
    if (ir[31:26] == OP_BEQ) return 3'b1_00;
    if (is_cal_r(ir) || is_shift_imm(ir) || is_mult(ir) || is_div(ir) || is_mt(ir)) return 3'b1_01;
    if (is_store(ir)) return 3'b1_10;
    return 3'b0_00;
  endfunction

  function automatic logic src_stall(input logic [2:0] use_t, input logic [4:0] src,
                                     input logic [4:0] d_e, input logic [1:0] t_e,
                                     input logic [4:0] d_m, input logic [1:0] t_m);
    return use_t[2] && (src != 5'd0) &&
           ((src == d_e && use_t[1:0] < t_e) || (src == d_m && use_t[1:0] < t_m));
  endfunction

  // ---------------- state ----------------
  logic [31:0] ir_d, ir_e, ir_m, ir_w;
  logic [31:0] pc_d, pc_e, pc_m, pc_w;
  logic [3:0]  md_cnt;
  logic        data_stall, md_stall, stall;

  always_comb begin
    data_stall = src_stall(rs_use_of(ir_d), ir_d[25:21],
                           dest_of(ir_e), tnew_e_of(ir_e), dest_of(ir_m), tnew_m_of(ir_m)) ||
                 src_stall(rt_use_of(ir_d), ir_d[20:16],
                           dest_of(ir_e), tnew_e_of(ir_e), dest_of(ir_m), tnew_m_of(ir_m));
    // An MD op in E has not yet loaded the counter, so it must be checked directly.
    md_stall   = is_md(ir_d) && (md_cnt != 4'd0 || is_mult(ir_e) || is_div(ir_e));
    stall      = data_stall || md_stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_d <= 32'd0;
      ir_e <= 32'd0;
      ir_m <= 32'd0;
      ir_w <= 32'd0;
      pc_d <= PC_RESET;
      pc_e <= PC_RESET;
      pc_m <= PC_RESET;
      pc_w <= PC_RESET;
    end else begin
      if (!stall) begin
        ir_d <= bus.IR_F;
        pc_d <= bus.PC_F;
      end
      ir_e <= stall ? 32'd0 : ir_d;
      pc_e <= pc_d;
      ir_m <= ir_e;
      pc_m <= pc_e;
      ir_w <= ir_m;
      pc_w <= pc_m;
    end
  end

  // Reload from E takes priority; a bubble in E is a NOP and never reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (is_mult(ir_e)) begin
      md_cnt <= MULT_LD;
    end else if (is_div(ir_e)) begin
      md_cnt <= DIV_LD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign bus.IR_D    = ir_d;
  assign bus.IR_E    = ir_e;
  assign bus.IR_M    = ir_m;
  assign bus.IR_W    = ir_w;
  assign bus.PC_D    = pc_d;
  assign bus.PC_E    = pc_e;
  assign bus.PC_M    = pc_m;
  assign bus.PC_W    = pc_w;
  assign bus.stall   = stall;
  assign bus.en_PC   = ~stall;
  assign bus.md_busy = (md_cnt != 4'd0);
  assign bus.md_cnt  = md_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_CYC(MULT_N),
    .DIV_CYC (DIV_N),
    .PC_RESET(PC_RST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int stall_seen = 0;
  bit chk_en = 0;
  bit rand_mode = 0;

  logic [31:0] m_ir [1:4];
  logic [31:0] m_pc [1:4];
  int          m_cnt;
  logic [31:0] prog [$];
  logic [31:0] next_pc;

  typedef struct {
    int dest;
    int use_rs;
    int use_rt;
    int tnew_e;
    int tnew_m;
    bit md;
    int md_load;
  } info_t;

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: role of each instruction straight from the hazard rules.
  function automatic info_t decode(input logic [31:0] ir);
    info_t d;
    int op, fn, rs, rt, rd;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    d = '{dest: 0, use_rs: -1, use_rt: -1, tnew_e: 0, tnew_m: 0, md: 0, md_load: 0};
    if (op == 0) begin
      if (fn inside {[32:39], 42, 43, 4, 6, 7}) begin
        d.dest = rd; d.use_rs = 1; d.use_rt = 1; d.tnew_e = 1;
      end else if (fn inside {0, 2, 3}) begin
        d.dest = rd; d.use_rt = 1; d.tnew_e = 1;
      end else if (fn inside {16, 18}) begin
        d.dest = rd; d.tnew_e = 1; d.md = 1;
      end else if (fn inside {17, 19}) begin
        d.use_rs = 1; d.use_rt = 1; d.md = 1;
      end else if (fn inside {24, 25, 26, 27}) begin
        d.use_rs = 1; d.use_rt = 1; d.md = 1;
        d.md_load = (fn < 26) ? MULT_N : DIV_N;
      end else if (fn == 8) begin
        d.use_rs = 0;
      end else if (fn == 9) begin
        d.use_rs = 0; d.dest = rd; d.tnew_e = 1;
      end
    end else if (op == 4) begin
      d.use_rs = 0; d.use_rt = 0;
    end else if (op == 3) begin
      d.dest = 31; d.tnew_e = 1;
    end else if (op >= 8 && op <= 15) begin
      d.dest = rt; d.use_rs = 1; d.tnew_e = 1;
    end else if (op inside {32, 33, 35, 36, 37}) begin
      d.dest = rt; d.use_rs = 1; d.tnew_e = 2; d.tnew_m = 1;
    end else if (op inside {40, 41, 43}) begin
      d.use_rs = 1; d.use_rt = 2;
    end
    return d;
  endfunction

  function automatic bit model_stall();
    info_t dd, de, dm;
    int src [2];
    int tu [2];
    dd = decode(m_ir[1]); de = decode(m_ir[2]); dm = decode(m_ir[3]);
    src[0] = int'(m_ir[1][25:21]); tu[0] = dd.use_rs;
    src[1] = int'(m_ir[1][20:16]); tu[1] = dd.use_rt;
    for (int k = 0; k < 2; k++) begin
      if (tu[k] >= 0 && src[k] != 0) begin
        if (src[k] == de.dest && tu[k] < de.tnew_e) return 1'b1;
        if (src[k] == dm.dest && tu[k] < dm.tnew_m) return 1'b1;
      end
    end
    return dd.md && (m_cnt != 0 || de.md_load != 0);
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 4; k++) begin
      m_ir[k] = 32'd0;
      m_pc[k] = PC_RST;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input bit st);
    info_t de;
    de = decode(m_ir[2]);
    if (de.md_load != 0) m_cnt = de.md_load;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    m_ir[4] = m_ir[3]; m_pc[4] = m_pc[3];
    m_ir[3] = m_ir[2]; m_pc[3] = m_pc[2];
    m_ir[2] = st ? 32'd0 : m_ir[1]; m_pc[2] = m_pc[1];
    if (!st) begin
      m_ir[1] = bus.IR_F; m_pc[1] = bus.PC_F;
    end
  endtask

  function automatic logic [4:0] rreg();
    int v;
    v = int'($urandom_range(0, 4));
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] mdf [8];
    mdf = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13};
    case ($urandom_range(0, 15))
      0:  return r_ins(6'h21, rreg(), rreg(), rreg());
      1:  return r_ins(6'h23, rreg(), rreg(), rreg());
      2:  return r_ins(6'h00, 5'd0, rreg(), rreg()) | {21'd0, 5'($urandom), 6'd0};
      3:  return r_ins(6'h04, rreg(), rreg(), rreg());
      4:  return i_ins(6'h23, rreg(), rreg(), 16'($urandom));
      5:  return i_ins(6'h20, rreg(), rreg(), 16'($urandom));
      6:  return i_ins(6'h2b, rreg(), rreg(), 16'($urandom));
      7:  return i_ins(6'h04, rreg(), rreg(), 16'($urandom));
      8:  return r_ins(6'h08, rreg(), 5'd0, 5'd0);
      9:  return r_ins(6'h09, rreg(), 5'd0, rreg());
      10: return i_ins(6'h09, rreg(), rreg(), 16'($urandom));
      11: return i_ins(6'h0f, 5'd0, rreg(), 16'($urandom));
      12: return {6'h03, 26'($urandom)};
      13: return r_ins(mdf[$urandom_range(0, 7)], rreg(), rreg(), rreg());
      14: return {6'h3f, 26'($urandom)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic fetch_next();
    if (prog.size() > 0) bus.IR_F = prog.pop_front();
    else if (rand_mode) bus.IR_F = rand_instr();
    else bus.IR_F = 32'd0;
    bus.PC_F = next_pc;
    next_pc  = next_pc + 32'd4;
  endtask

  task automatic cycle();
    bit st;
    st = model_stall();
    @(posedge clk);
    model_step(st);
    #1;
    if (!st) fetch_next();
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("IR_D", bus.IR_D, m_ir[1]);
      chk("IR_E", bus.IR_E, m_ir[2]);
      chk("IR_M", bus.IR_M, m_ir[3]);
      chk("IR_W", bus.IR_W, m_ir[4]);
      chk("PC_D", bus.PC_D, m_pc[1]);
      chk("PC_E", bus.PC_E, m_pc[2]);
      chk("PC_M", bus.PC_M, m_pc[3]);
      chk("PC_W", bus.PC_W, m_pc[4]);
      chk("stall", 32'(bus.stall), 32'(model_stall()));
      chk("en_PC", 32'(bus.en_PC), 32'(!model_stall()));
      chk("md_busy", 32'(bus.md_busy), 32'(m_cnt != 0));
      chk("md_cnt", 32'(bus.md_cnt), 32'(m_cnt));
      if (bus.stall) stall_seen++;
    end
  end

  task automatic run_pair(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int n, input int exp_stalls);
    prog.push_back(a);
    prog.push_back(b);
    stall_seen = 0;
    repeat (n) cycle();
    chk(name, 32'(stall_seen), 32'(exp_stalls));
  endtask

  localparam logic [31:0] ADDU3 = 32'h0022_1821;  // addu $3,$1,$2

  initial begin
    logic [31:0] mflo3;
    mflo3 = r_ins(6'h12, 5'd0, 5'd0, 5'd3);

    // Reset with addu in F, then release: 4-cycle latency to W.
    reset = 1'b1;
    bus.IR_F = ADDU3;
    bus.PC_F = 32'h0000_1000;
    next_pc = 32'h0000_1004;
    model_reset();
    chk_en = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    stall_seen = 0;
    cycle();
    chk("lat_ir_d_1edge", bus.IR_D, ADDU3);
    repeat (3) cycle();
    chk("lat_ir_w_4edges", bus.IR_W, ADDU3);
    chk("lat_pc_w", bus.PC_W, 32'h0000_1000);
    chk("lat_no_stall", 32'(stall_seen), 32'd0);
    repeat (4) cycle();

    run_pair("lw_addu_stalls", i_ins(6'h23, 5'd0, 5'd5, 16'd0), r_ins(6'h21, 5'd5, 5'd5, 5'd6), 12, 1);
    run_pair("lw_beq_stalls",  i_ins(6'h23, 5'd0, 5'd5, 16'd0), i_ins(6'h04, 5'd5, 5'd0, 16'd0), 12, 2);
    run_pair("addu_jr_stalls", r_ins(6'h21, 5'd1, 5'd2, 5'd4), r_ins(6'h08, 5'd4, 5'd0, 5'd0), 12, 1);
    run_pair("addu_sw_stalls", r_ins(6'h21, 5'd1, 5'd2, 5'd4), i_ins(6'h2b, 5'd0, 5'd4, 16'd0), 12, 0);
    run_pair("mult_mflo_stalls", r_ins(6'h18, 5'd1, 5'd2, 5'd0), mflo3, 20, 6);
    run_pair("div_mflo_stalls",  r_ins(6'h1a, 5'd1, 5'd2, 5'd0), mflo3, 26, 11);

    // Reset mid-busy and mid-stall: everything clears with no clock edge.
    prog.push_back(r_ins(6'h1a, 5'd1, 5'd2, 5'd0));
    prog.push_back(mflo3);
    for (int k = 0; k < 30 && m_cnt != 7; k++) cycle();
    chk("busy_cnt_7", 32'(bus.md_cnt), 32'd7);
    chk("busy_stall_1", 32'(bus.stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_md_cnt", 32'(bus.md_cnt), 32'd0);
    chk("async_stall", 32'(bus.stall), 32'd0);
    chk("async_md_busy", 32'(bus.md_busy), 32'd0);
    chk("async_ir_d", bus.IR_D, 32'd0);
    chk("async_ir_e", bus.IR_E, 32'd0);
    chk("async_ir_m", bus.IR_M, 32'd0);
    chk("async_ir_w", bus.IR_W, 32'd0);
    chk("async_pc_w", bus.PC_W, PC_RST);
    model_reset();
    prog.delete();
    @(negedge clk);
    #1 reset = 1'b0;

    // Randomized traffic checked every cycle by the compare process.
    rand_mode = 1'b1;
    repeat (800) cycle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
